a2d_sched: RTL and testbench

Round-robin conversion scheduler that shares one SPI A2D master between the four analog channels of the balance platform: left load cell, right load cell, steer potentiometer and battery. Each `nxt` request runs one two-transaction A2D conversion on the current channel, stores the 12-bit result in that channel's holding register, and advances the channel pointer. The `lft_ld`/`rght_ld` outputs feed the steer-enable logic; `steer_pot` and `batt` feed the steering and battery-monitor paths.

---
 rtl/a2d_sched.sv | 108 ++++++++++
 tb/tb_a2d_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/a2d_sched.sv
// a2d_sched: round-robin scheduler sharing one SPI A2D master across four analog channels.
module a2d_sched #(
  parameter int TIMEOUT = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nxt,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic [11:0] steer_pot,
  output logic [11:0] batt,
  output logic        cnv_cmplt,
  output logic        rnd_cmplt,
  output logic        err
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SEND_CH = 3'd1;
  localparam logic [2:0] WAIT_CH = 3'd2;
  localparam logic [2:0] SEND_RD = 3'd3;
  localparam logic [2:0] WAIT_RD = 3'd4;

  logic [2:0]    r_state;
  logic [1:0]    r_idx;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_cmd;
  logic [11:0]   r_lft, r_rght, r_steer, r_batt;
  logic          r_wrt, r_cnv, r_rnd, r_err;
  logic [2:0]    w_ch;
  logic          w_to;

  // idx 0 is channel 0; idx 1..3 map onto channels 4..6
  always_comb begin
    w_ch = (r_idx == 2'd0) ? 3'd0 : {1'b1, 2'(r_idx - 2'd1)};
    w_to = (r_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_cnt   <= '0;
      r_cmd   <= 16'h0000;
      r_lft   <= 12'h000;
      r_rght  <= 12'h000;
      r_steer <= 12'h000;
      r_batt  <= 12'h000;
      r_wrt   <= 1'b0;
      r_cnv   <= 1'b0;
      r_rnd   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_wrt <= 1'b0;
      r_cnv <= 1'b0;
      r_rnd <= 1'b0;
      case (r_state)
        IDLE: if (nxt) begin
          r_cmd   <= {2'b00, w_ch, 11'h000};
          r_wrt   <= 1'b1;
          r_state <= SEND_CH;
        end
        SEND_CH: begin
          r_cnt   <= '0;
          r_state <= WAIT_CH;
        end
        WAIT_CH: if (done) begin
          r_wrt   <= 1'b1;
          r_state <= SEND_RD;
        end else if (w_to) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 1'b1;
        SEND_RD: begin
          r_cnt   <= '0;
          r_state <= WAIT_RD;
        end
        WAIT_RD: if (done) begin
          if (r_idx == 2'd0) r_lft <= rd_data[11:0];
          if (r_idx == 2'd1) r_rght <= rd_data[11:0];
          if (r_idx == 2'd2) r_steer <= rd_data[11:0];
          if (r_idx == 2'd3) r_batt <= rd_data[11:0];
          r_cnv   <= 1'b1;
          r_rnd   <= (r_idx == 2'd3);
          r_idx   <= r_idx + 2'd1;
          r_state <= IDLE;
        end else if (w_to) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign wrt       = r_wrt;
  assign cmd       = r_cmd;
  assign lft_ld    = r_lft;
  assign rght_ld   = r_rght;
  assign steer_pot = r_steer;
  assign batt      = r_batt;
  assign cnv_cmplt = r_cnv;
  assign rnd_cmplt = r_rnd;
  assign err       = r_err;
endmodule

// File: tb/tb_a2d_sched.sv
// tb_a2d_sched: directed bench; instance 0 uses the default timeout, instance 1 uses TIMEOUT=16.
module tb_a2d_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        nxt[2], done[2], wrt[2], cnv[2], rnd[2], err[2];
  logic [15:0] rd[2], cmd[2];
  logic [11:0] lft[2], rght[2], steer[2], batt[2];
  logic [15:0] cmd_tab[4];
  int vec = 0, fails = 0;

  always #5 clk = ~clk;

  a2d_sched u0 (.clk(clk), .rst_n(rst_n), .nxt(nxt[0]), .done(done[0]), .rd_data(rd[0]),
    .wrt(wrt[0]), .cmd(cmd[0]), .lft_ld(lft[0]), .rght_ld(rght[0]), .steer_pot(steer[0]),
    .batt(batt[0]), .cnv_cmplt(cnv[0]), .rnd_cmplt(rnd[0]), .err(err[0]));

  a2d_sched #(.TIMEOUT(16)) u1 (.clk(clk), .rst_n(rst_n), .nxt(nxt[1]), .done(done[1]),
    .rd_data(rd[1]), .wrt(wrt[1]), .cmd(cmd[1]), .lft_ld(lft[1]), .rght_ld(rght[1]),
    .steer_pot(steer[1]), .batt(batt[1]), .cnv_cmplt(cnv[1]), .rnd_cmplt(rnd[1]), .err(err[1]));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] res(input int d, input logic [1:0] ix);
    return ix == 2'd0 ? lft[d] : ix == 2'd1 ? rght[d] : ix == 2'd2 ? steer[d] : batt[d];
  endfunction

  task automatic reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic chk_rst(input int d);
    chk("rst_wrt", wrt[d], 0);
    chk("rst_cmd", cmd[d], 0);
    chk("rst_regs", {lft[d], rght[d], steer[d], batt[d]}, 0);
    chk("rst_flags", {cnv[d], rnd[d], err[d]}, 0);
  endtask

  // one conversion: done l1 cycles after the first wrt, l2 after the second
  task automatic conv(input int d, input logic [1:0] ix, input logic [15:0] data,
                      input int l1, input int l2, input bit busy);
    nxt[d] = 1'b1;
    step();
    nxt[d] = 1'b0;
    chk("wrt_ch", wrt[d], 1);
    chk("cmd_ch", cmd[d], cmd_tab[ix]);
    for (int i = 0; i < l1; i++) begin
      step();
      chk("wrt_wait_ch", wrt[d], 0);
    end
    done[d] = 1'b1;
    rd[d] = 16'hDEAD;
    step();
    done[d] = 1'b0;
    chk("wrt_rd", wrt[d], 1);
    chk("cmd_rd", cmd[d], cmd_tab[ix]);
    if (busy) nxt[d] = 1'b1;
    for (int i = 0; i < l2; i++) begin
      step();
      chk("wrt_wait_rd", {wrt[d], cnv[d]}, 0);
    end
    nxt[d] = 1'b0;
    done[d] = 1'b1;
    rd[d] = data;
    step();
    done[d] = 1'b0;
    chk("result", res(d, ix), data[11:0]);
    chk("cnv_pulse", cnv[d], 1);
    chk("rnd_pulse", rnd[d], ix == 2'd3);
    chk("wrt_idle", wrt[d], 0);
    step();
    chk("pulse_end", {cnv[d], rnd[d], wrt[d]}, 0);
  endtask

  initial begin
    cmd_tab[0] = 16'h0000; cmd_tab[1] = 16'h2000; cmd_tab[2] = 16'h2800; cmd_tab[3] = 16'h3000;
    for (int d = 0; d < 2; d++) begin
      nxt[d] = 1'b0; done[d] = 1'b0; rd[d] = 16'h0000;
    end
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk_rst(0);
    chk_rst(1);

    conv(0, 0, 16'hF5A3, 32, 32, 0);
    chk("single_lft", lft[0], 12'h5A3);
    chk("single_others", {rght[0], steer[0], batt[0]}, 0);

    reset();
    conv(0, 0, 16'h0111, 32, 32, 0);
    conv(0, 1, 16'h0222, 7, 9, 0);
    conv(0, 2, 16'h0333, 1, 2, 0);
    conv(0, 3, 16'h0444, 4, 3, 0);
    chk("round_regs", {lft[0], rght[0], steer[0], batt[0]}, 48'h111_222_333_444);

    conv(0, 0, 16'hBABC, 5, 6, 1);
    chk("fifth_lft", lft[0], 12'hABC);
    done[0] = 1'b1;
    rd[0] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("spurious_done", {wrt[0], cnv[0], rnd[0]}, 0);
    end
    done[0] = 1'b0;
    chk("spurious_regs", {lft[0], rght[0], steer[0], batt[0]}, 48'hABC_222_333_444);

    conv(0, 1, 16'h0555, 2, 2, 0);
    nxt[0] = 1'b1;
    step();
    nxt[0] = 1'b0;
    chk("midop_cmd", cmd[0], 16'h2800);
    for (int i = 0; i < 3; i++) step();
    done[0] = 1'b1;
    step();
    done[0] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    reset();
    chk_rst(0);
    done[0] = 1'b1;
    rd[0] = 16'hFFFF;
    step();
    done[0] = 1'b0;
    step();
    chk("late_done", {wrt[0], cnv[0], lft[0], rght[0], steer[0], batt[0]}, 0);
    conv(0, 0, 16'h0999, 2, 2, 0);

    reset();
    nxt[1] = 1'b1;
    step();
    nxt[1] = 1'b0;
    chk("to_wrt", wrt[1], 1);
    chk("to_cmd", cmd[1], 16'h0000);
    for (int i = 0; i < 16; i++) begin
      step();
      chk("to_err_early", {err[1], wrt[1]}, 0);
    end
    step();
    chk("to_err_set", err[1], 1);
    chk("to_regs", {lft[1], cnv[1]}, 0);
    step();
    step();
    chk("to_idle", wrt[1], 0);
    conv(1, 0, 16'h0123, 5, 5, 0);
    chk("to_err_sticky", err[1], 1);

    reset();
    conv(1, 0, 16'h0777, 3, 16, 0);
    chk("sim_err", err[1], 0);
    chk("sim_lft", lft[1], 12'h777);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
